// File: rtl/mem_ctrl_pkg.sv
// Shared types for the DRAM request port: access-size encodings, port states,
// the default DRAM base address and access-size helpers.
package mem_ctrl_pkg;

    localparam logic [63:0] DRAM_BASE_DEF = 64'h8000_0000;

    typedef enum logic [2:0] {
        RD_NONE = 3'b000,
        RD_LB   = 3'b001,
        RD_LBU  = 3'b010,
        RD_LH   = 3'b011,
        RD_LHU  = 3'b100,
        RD_LW   = 3'b101,
        RD_LD   = 3'b110,
        RD_LWU  = 3'b111
    } rd_ctrl_e;

    typedef enum logic [2:0] {
        WR_NONE = 3'b000,
        WR_SB   = 3'b001,
        WR_SH   = 3'b010,
        WR_SW   = 3'b011,
        WR_SD   = 3'b100
    } wr_ctrl_e;

    typedef enum logic [1:0] {
        ST_READY   = 2'b00,
        ST_BUSY_RD = 2'b01,
        ST_BUSY_WR = 2'b10,
        ST_ERROR   = 2'b11
    } dram_state_e;

    function automatic logic [3:0] rd_bytes(rd_ctrl_e c);
        logic [3:0] n;
        n = 4'd0;
        case (c)
            RD_LB, RD_LBU:  n = 4'd1;
            RD_LH, RD_LHU:  n = 4'd2;
            RD_LW, RD_LWU:  n = 4'd4;
            RD_LD:          n = 4'd8;
            default:        n = 4'd0;
        endcase
        return n;
    endfunction

    function automatic logic [3:0] wr_bytes(wr_ctrl_e c);
        logic [3:0] n;
        n = 4'd0;
        case (c)
            WR_SB:   n = 4'd1;
            WR_SH:   n = 4'd2;
            WR_SW:   n = 4'd4;
            WR_SD:   n = 4'd8;
            default: n = 4'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dram_port_ctrl_if.sv
// Request/response bundle between the dcache/mem stage (master) and the
// DRAM responder (slave).
interface dram_port_ctrl_if;

    logic [63:0] addr;
    logic [63:0] din;
    logic [2:0]  rd_ctrl;
    logic [2:0]  wr_ctrl;
    logic [63:0] dout;
    logic [1:0]  state;

    modport master (
        output addr, din, rd_ctrl, wr_ctrl,
        input  dout, state
    );

    modport slave (
        input  addr, din, rd_ctrl, wr_ctrl,
        output dout, state
    );

endinterface

// File: rtl/dram_store.sv
// Word-organised backing store: synchronous byte-enabled write,
// combinational word read. Contents are not reset.
module dram_store #(
    parameter  int MEM_WORDS = 4096,
    localparam int IW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [7:0]    be,
    input  logic [IW-1:0] idx,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);

    logic [63:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 8; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dram_port_ctrl.sv
// DRAM port responder: one sized access per request after LATENCY busy cycles.
// Define DRAM_PORT_ERR_EN to report illegal requests via the ERROR state.
module dram_port_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [63:0] DRAM_BASE = DRAM_BASE_DEF,
    parameter int          MEM_WORDS = 4096,
    parameter int          LATENCY   = 2
) (
    input  logic         clk,
    input  logic         rst,
    dram_port_ctrl_if.slave port
);

    localparam int          IW   = $clog2(MEM_WORDS);
    localparam int          CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [63:0] SPAN = 64'(MEM_WORDS) << 3;

    dram_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   a_q, d_q, dout_q;
    rd_ctrl_e      rd_q, rd_in, rd_cap;
    wr_ctrl_e      wr_q, wr_in;

    logic rd_req, wr_req, req;
    logic accept, done;

    assign rd_in  = rd_ctrl_e'(port.rd_ctrl);
    assign rd_req = (port.rd_ctrl != 3'b000);
    assign wr_req = (port.wr_ctrl != 3'b000) && (port.wr_ctrl <= 3'b100);
    assign wr_in  = wr_req ? wr_ctrl_e'(port.wr_ctrl) : WR_NONE;
    assign req    = rd_req | wr_req;

    // Without error reporting a combined request degrades to the write alone
`ifdef DRAM_PORT_ERR_EN
    assign rd_cap = rd_in;
`else
    assign rd_cap = wr_req ? RD_NONE : rd_in;
`endif

    logic          is_wr;
    logic [3:0]    nbytes;
    logic [2:0]    amask, lane;
    logic [63:0]   off;
    logic          in_range;
    logic          err;
    logic [IW-1:0] idx;
    logic [7:0]    bmask, wbe;
    logic [63:0]   wdata, rword, sh, rd_val;
    logic          we;

    assign is_wr    = (wr_q != WR_NONE);
    assign nbytes   = is_wr ? wr_bytes(wr_q) : rd_bytes(rd_q);
    assign amask    = 3'(nbytes - 4'd1);
    assign lane     = a_q[2:0] & ~amask;
    assign off      = a_q - DRAM_BASE;
    assign in_range = (a_q >= DRAM_BASE) && (off < SPAN);
    assign idx      = off[IW+2:3];

`ifdef DRAM_PORT_ERR_EN
    logic is_rd, misal, both;
    assign is_rd = (rd_q != RD_NONE);
    assign misal = |(a_q[2:0] & amask);
    assign both  = is_wr && is_rd;
    assign err   = !in_range || misal || both;
`else
    assign err   = 1'b0;
`endif

    assign bmask = 8'((9'h1 << nbytes) - 9'h1);
    assign wbe   = bmask << lane;
    assign wdata = d_q << {lane, 3'b000};
    assign we    = done && is_wr && in_range && !err;

    dram_store #(
        .MEM_WORDS(MEM_WORDS)
    ) u_store (
        .clk  (clk),
        .we   (we),
        .be   (wbe),
        .idx  (idx),
        .wdata(wdata),
        .rdata(rword)
    );

    assign sh = rword >> {lane, 3'b000};

    always_comb begin
        rd_val = '0;
        case (rd_q)
            RD_LB:   rd_val = {{56{sh[7]}}, sh[7:0]};
            RD_LBU:  rd_val = {56'b0, sh[7:0]};
            RD_LH:   rd_val = {{48{sh[15]}}, sh[15:0]};
            RD_LHU:  rd_val = {48'b0, sh[15:0]};
            RD_LW:   rd_val = {{32{sh[31]}}, sh[31:0]};
            RD_LWU:  rd_val = {32'b0, sh[31:0]};
            RD_LD:   rd_val = sh;
            default: rd_val = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            ST_READY, ST_ERROR: begin
                if (req) begin
                    accept  = 1'b1;
                    state_d = wr_req ? ST_BUSY_WR : ST_BUSY_RD;
                    cnt_d   = CW'(LATENCY - 1);
                end else begin
                    state_d = ST_READY;
                end
            end
            ST_BUSY_RD, ST_BUSY_WR: begin
                if (cnt_q == '0) begin
                    done    = 1'b1;
                    state_d = err ? ST_ERROR : ST_READY;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = ST_READY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q  <= '0;
            d_q  <= '0;
            rd_q <= RD_NONE;
            wr_q <= WR_NONE;
        end else if (accept) begin
            a_q  <= port.addr;
            d_q  <= port.din;
            rd_q <= rd_cap;
            wr_q <= wr_in;
        end
    end

    // Writes leave dout alone; an illegal request always reports zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q <= '0;
        end else if (done) begin
            if (err)         dout_q <= '0;
            else if (!is_wr) dout_q <= in_range ? rd_val : '0;
        end
    end

    assign port.dout  = dout_q;
    assign port.state = state_q;

endmodule
